// File: rtl/div_if.sv
// Divider handshake bundle between the EX stage and the divider.
// master: EX stage side, slave: divider side.
interface div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/div.sv
// Multi-cycle restoring divider, 32-bit operands, {rem, quo} result.
// Define DIV_SIGNED_EN to honour signed_div_i; otherwise always unsigned.
module div (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    localparam logic [1:0] DIV_FREE    = 2'b00;
    localparam logic [1:0] DIV_BY_ZERO = 2'b01;
    localparam logic [1:0] DIV_ON      = 2'b10;
    localparam logic [1:0] DIV_END     = 2'b11;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [64:0] work;
    logic [31:0] divisor;
    logic [63:0] result;
    logic        ready;

    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    logic [64:0] shifted;
    logic [32:0] diff;
    logic [64:0] step;

    logic        accept;

`ifdef DIV_SIGNED_EN
    logic        q_neg;
    logic        r_neg;
    logic        neg1;
    logic        neg2;

    assign neg1 = bus.signed_div_i & bus.opdata1_i[31];
    assign neg2 = bus.signed_div_i & bus.opdata2_i[31];
    assign mag1 = neg1 ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
    assign mag2 = neg2 ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
    assign quo_fix = q_neg ? (~work[31:0] + 32'd1) : work[31:0];
    assign rem_fix = r_neg ? (~work[63:32] + 32'd1) : work[63:32];

    // Capture the result signs at operand latch time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state == DIV_FREE && accept) begin
            q_neg <= neg1 ^ neg2;
            r_neg <= neg1;
        end
    end
`else
    assign mag1    = bus.opdata1_i;
    assign mag2    = bus.opdata2_i;
    assign quo_fix = work[31:0];
    assign rem_fix = work[63:32];
`endif

    assign accept = bus.start_i & ~bus.annul_i;

    // Partial remainder never reaches the divisor, so bit 64 stays 0.
    assign shifted = work << 1;
    assign diff    = shifted[64:32] - {1'b0, divisor};
    assign step    = diff[32] ? shifted
                              : {diff, shifted[31:1], 1'b1};

    assign bus.result_o   = result;
    assign bus.ready_o    = ready;
    assign bus.stallreq_o = bus.start_i & ~bus.annul_i & ~ready;

    // Divider FSM: latch operands, iterate 32 steps, publish result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= DIV_FREE;
            cnt     <= 6'd0;
            work    <= 65'd0;
            divisor <= 32'd0;
            result  <= 64'd0;
            ready   <= 1'b0;
        end else begin
            case (state)
                DIV_FREE: begin
                    ready  <= 1'b0;
                    result <= 64'd0;
                    if (accept) begin
                        cnt     <= 6'd0;
                        work    <= {33'd0, mag1};
                        divisor <= mag2;
                        if (bus.opdata2_i == 32'd0)
                            state <= DIV_BY_ZERO;
                        else
                            state <= DIV_ON;
                    end
                end
                DIV_BY_ZERO: begin
                    if (accept) begin
                        result <= 64'd0;
                        ready  <= 1'b1;
                        state  <= DIV_END;
                    end else begin
                        state <= DIV_FREE;
                    end
                end
                DIV_ON: begin
                    if (!accept) begin
                        state <= DIV_FREE;
                        cnt   <= 6'd0;
                    end else if (cnt == 6'd32) begin
                        result <= {rem_fix, quo_fix};
                        ready  <= 1'b1;
                        state  <= DIV_END;
                        cnt    <= 6'd0;
                    end else begin
                        work <= step;
                        cnt  <= cnt + 6'd1;
                    end
                end
                default: begin
                    if (!bus.start_i) begin
                        state  <= DIV_FREE;
                        ready  <= 1'b0;
                        result <= 64'd0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div.sv
// Directed testbench for the multi-cycle divider.
// Expected values are hand-computed for the build's DIV_SIGNED_EN setting.
module tb_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    div_if bus ();

    div u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat);
        int  n;
        bit  stall_bad;
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        #1;
        chk({tag, "_stall0"}, 64'(bus.stallreq_o), 64'd1);
        n = 0;
        stall_bad = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!bus.ready_o && !bus.stallreq_o) stall_bad = 1'b1;
        end while (!bus.ready_o && n < 60);
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_res"}, bus.result_o, exp);
        chk({tag, "_stall_hold"}, 64'(stall_bad), 64'd0);
        chk({tag, "_stall_rdy"}, 64'(bus.stallreq_o), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_hold"}, bus.result_o, exp);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_drop_rdy"}, 64'(bus.ready_o), 64'd0);
        chk({tag, "_drop_res"}, bus.result_o, 64'd0);
    endtask

    initial begin
        int  hits;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        #1;
        chk("rst_ready", 64'(bus.ready_o), 64'd0);
        chk("rst_result", bus.result_o, 64'd0);
        chk("rst_stall", 64'(bus.stallreq_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);
        run("u_max", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 34);
        run("u_small", 1'b0, 32'd5, 32'd9, 64'h00000005_00000000, 34);
        run("u_big", 1'b0, 32'hFFFFFFFF, 32'h10000, 64'h0000FFFF_0000FFFF, 34);
        run("div0", 1'b0, 32'd1234, 32'd0, 64'd0, 2);
`ifdef DIV_SIGNED_EN
        run("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34);
        run("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
        run("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);
        run("u_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 34);
`else
        run("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 34);
        run("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 34);
`endif

        // annul mid-operation, then annul holding off a start
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        chk("annul_rdy", 64'(bus.ready_o), 64'd0);
        hits = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.ready_o || bus.stallreq_o) hits++;
        end
        chk("annul_block", 64'(hits), 64'd0);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        hits = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) hits++;
        end
        chk("annul_quiet", 64'(hits), 64'd0);
        run("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);

        // reset in the middle of an operation
        @(negedge clk);
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        repeat (16) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.start_i = 1'b0;
        #1;
        chk("rst_on_rdy", 64'(bus.ready_o), 64'd0);
        chk("rst_on_res", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) hits++;
        end
        chk("rst_on_quiet", 64'(hits), 64'd0);

        // asynchronous reset clears a held result mid-cycle
        @(negedge clk);
        bus.start_i = 1'b1;
        repeat (34) @(posedge clk);
        #1;
        chk("rst_end_pre", bus.result_o, 64'h00000002_0000000E);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_end_res", bus.result_o, 64'd0);
        chk("rst_end_rdy", 64'(bus.ready_o), 64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_end_quiet", 64'(bus.ready_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
